// File: rtl/arbitro_memoria_tabuleiro_if.sv
// rtl/arbitro_memoria_tabuleiro_if.sv - board memory arbiter bus: two requesters, VGA port, memory and read-return
interface arbitro_memoria_tabuleiro_if #(
  parameter int ADDR_W = 5
);
  logic              col_req;
  logic              col_jogador;
  logic              col_we;
  logic [ADDR_W-1:0] col_addr;
  logic [63:0]       col_wdata;
  logic              col_gnt;

  logic              val_req;
  logic              val_jogador;
  logic              val_we;
  logic [ADDR_W-1:0] val_addr;
  logic [63:0]       val_wdata;
  logic              val_gnt;

  logic              vga_jogador;
  logic [ADDR_W-1:0] vga_addr;

  logic [63:0]       mem_rdata_p1;
  logic [63:0]       mem_rdata_p2;
  logic [ADDR_W-1:0] mem_addr;
  logic [63:0]       mem_wdata;
  logic              wrenP1;
  logic              wrenP2;

  logic [63:0]       rd_data;
  logic              rd_valid;
  logic [1:0]        rd_src;

  modport master (
    output col_req, col_jogador, col_we, col_addr, col_wdata,
    output val_req, val_jogador, val_we, val_addr, val_wdata,
    output vga_jogador, vga_addr, mem_rdata_p1, mem_rdata_p2,
    input  col_gnt, val_gnt, mem_addr, mem_wdata, wrenP1, wrenP2,
    input  rd_data, rd_valid, rd_src
  );

  modport slave (
    input  col_req, col_jogador, col_we, col_addr, col_wdata,
    input  val_req, val_jogador, val_we, val_addr, val_wdata,
    input  vga_jogador, vga_addr, mem_rdata_p1, mem_rdata_p2,
    output col_gnt, val_gnt, mem_addr, mem_wdata, wrenP1, wrenP2,
    output rd_data, rd_valid, rd_src
  );
endinterface

// File: rtl/arbitro_memoria_tabuleiro.sv
// rtl/arbitro_memoria_tabuleiro.sv - shares the two board memories between colisor, validador and VGA
module arbitro_memoria_tabuleiro #(
  parameter int MAX_BURST = 32,
  parameter int ADDR_W    = 5
) (
  input  logic clk,
  input  logic resetGeral,
  arbitro_memoria_tabuleiro_if.slave bus
);
  typedef enum logic [1:0] {S_VGA, S_COL, S_VAL, S_GAP} state_t;

  localparam logic [5:0] BURST_LAST = 6'(MAX_BURST - 1);

  state_t            state;
  logic [5:0]        burst_cnt;
  logic              gap_from_val;
  logic              rd_valid_q;
  logic [1:0]        rd_src_q;
  logic              rd_jog_q;

  logic              col_gnt, val_gnt;
  logic              acc_we, acc_jog;
  logic [ADDR_W-1:0] acc_addr;
  logic [1:0]        acc_src;
  logic              burst_last;

  always_comb begin
    col_gnt    = (state == S_COL) && bus.col_req;
    val_gnt    = (state == S_VAL) && bus.val_req;
    acc_we     = 1'b0;
    acc_jog    = bus.vga_jogador;
    acc_addr   = bus.vga_addr;
    acc_src    = 2'd0;
    if (col_gnt) begin
      acc_we   = bus.col_we;
      acc_jog  = bus.col_jogador;
      acc_addr = bus.col_addr;
      acc_src  = 2'd1;
    end else if (val_gnt) begin
      acc_we   = bus.val_we;
      acc_jog  = bus.val_jogador;
      acc_addr = bus.val_addr;
      acc_src  = 2'd2;
    end
    burst_last = burst_cnt >= BURST_LAST;
  end

  assign bus.col_gnt   = col_gnt;
  assign bus.val_gnt   = val_gnt;
  assign bus.mem_addr  = acc_addr;
  assign bus.wrenP1    = acc_we && !acc_jog;
  assign bus.wrenP2    = acc_we && acc_jog;
  assign bus.mem_wdata = !acc_we ? 64'd0 : (col_gnt ? bus.col_wdata : bus.val_wdata);
  // Memories have one cycle of read latency, so the word arrives while the strobe is high.
  assign bus.rd_data   = !rd_valid_q ? 64'd0 : (rd_jog_q ? bus.mem_rdata_p2 : bus.mem_rdata_p1);
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_src    = rd_src_q;

  always_ff @(posedge clk or negedge resetGeral) begin
    if (!resetGeral) begin
      state        <= S_VGA;
      burst_cnt    <= 6'd0;
      gap_from_val <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_src_q     <= 2'd0;
      rd_jog_q     <= 1'b0;
    end else begin
      rd_valid_q <= !acc_we;
      rd_src_q   <= acc_we ? 2'd0 : acc_src;
      rd_jog_q   <= acc_jog;
      case (state)
        S_VGA: begin
          burst_cnt <= 6'd0;
          if (bus.col_req)      state <= S_COL;
          else if (bus.val_req) state <= S_VAL;
        end
        S_COL: begin
          if (bus.col_req) begin
            if (burst_last) begin
              state        <= S_GAP;
              gap_from_val <= 1'b0;
              burst_cnt    <= 6'd0;
            end else begin
              burst_cnt <= burst_cnt + 6'd1;
            end
          end else begin
            burst_cnt <= 6'd0;
            state     <= bus.val_req ? S_VAL : S_VGA;
          end
        end
        S_VAL: begin
          if (bus.val_req) begin
            if (burst_last) begin
              state        <= S_GAP;
              gap_from_val <= 1'b1;
              burst_cnt    <= 6'd0;
            end else begin
              burst_cnt <= burst_cnt + 6'd1;
            end
          end else begin
            burst_cnt <= 6'd0;
            state     <= bus.col_req ? S_COL : S_VGA;
          end
        end
        default: begin
          // After a forced VGA slot the requester that was waiting goes first.
          burst_cnt <= 6'd0;
          if (gap_from_val) begin
            if (bus.col_req)      state <= S_COL;
            else if (bus.val_req) state <= S_VAL;
            else                  state <= S_VGA;
          end else begin
            if (bus.val_req)      state <= S_VAL;
            else if (bus.col_req) state <= S_COL;
            else                  state <= S_VGA;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_arbitro_memoria_tabuleiro.sv
// tb/tb_arbitro_memoria_tabuleiro.sv - vector table, corner sequences and random run against a reference model
module tb_arbitro_memoria_tabuleiro;
  localparam int AW   = 5;
  localparam int MAXB = 32;

  logic clk = 1'b0;
  logic resetGeral = 1'b0;
  always #5 clk = ~clk;

  arbitro_memoria_tabuleiro_if #(.ADDR_W(AW)) bus ();
  arbitro_memoria_tabuleiro #(.MAX_BURST(MAXB), .ADDR_W(AW)) dut (
    .clk(clk), .resetGeral(resetGeral), .bus(bus)
  );

  logic [63:0] mem1 [32];
  logic [63:0] mem2 [32];
  logic        init_mem = 1'b1;

  // Board memories: synchronous read, read-before-write.
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 32; i++) begin
        mem1[i] <= {32'hA1A1_0000, 32'(i)};
        mem2[i] <= {32'hB2B2_0000, 32'(i)};
      end
    end else begin
      bus.mem_rdata_p1 <= mem1[bus.mem_addr];
      bus.mem_rdata_p2 <= mem2[bus.mem_addr];
      if (bus.wrenP1) mem1[bus.mem_addr] <= bus.mem_wdata;
      if (bus.wrenP2) mem2[bus.mem_addr] <= bus.mem_wdata;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic cr, input logic cw, input logic cj, input logic [4:0] ca,
                       input logic vr, input logic vw, input logic vj, input logic [4:0] va,
                       input logic gj, input logic [4:0] ga);
    bus.col_req = cr; bus.col_we = cw; bus.col_jogador = cj; bus.col_addr = ca;
    bus.val_req = vr; bus.val_we = vw; bus.val_jogador = vj; bus.val_addr = va;
    bus.vga_jogador = gj; bus.vga_addr = ga;
    bus.col_wdata = 64'hFF;
    bus.val_wdata = 64'hAA;
  endtask

  typedef struct {
    logic cr, cw, cj; logic [4:0] ca;
    logic vr, vw, vj; logic [4:0] va;
    logic gj; logic [4:0] ga;
    logic e_cg, e_vg, e_w1, e_w2; logic [4:0] e_addr; logic e_rv; logic [1:0] e_rs;
  } vec_t;

  vec_t tbl [15];

  // Reference model state
  int          m_holder, m_run, m_prev;
  bit          m_gap;
  bit          p_valid;
  logic [1:0]  p_src;
  logic [63:0] p_data;

  initial begin
    int n;
    logic [63:0] pend_data;
    logic        jg;

    tbl[0]  = '{0,0,0,0, 0,0,0,0, 1,7,  0,0,0,0,7,0,0};
    tbl[1]  = '{0,0,0,0, 0,0,0,0, 1,7,  0,0,0,0,7,1,0};
    tbl[2]  = '{1,1,0,3, 0,0,0,0, 1,7,  0,0,0,0,7,1,0};
    tbl[3]  = '{1,1,0,3, 0,0,0,0, 1,7,  1,0,1,0,3,1,0};
    tbl[4]  = '{0,1,0,3, 1,0,1,5, 1,7,  0,0,0,0,7,0,0};
    tbl[5]  = '{0,0,0,0, 1,0,1,5, 1,7,  0,1,0,0,5,1,0};
    tbl[6]  = '{0,0,0,0, 0,0,1,5, 1,7,  0,0,0,0,7,1,2};
    tbl[7]  = '{0,0,0,0, 0,0,0,0, 1,7,  0,0,0,0,7,1,0};
    tbl[8]  = '{1,0,1,9, 1,0,1,5, 1,7,  0,0,0,0,7,1,0};
    tbl[9]  = '{1,0,1,9, 1,0,1,5, 1,7,  1,0,0,0,9,1,0};
    tbl[10] = '{0,0,1,9, 1,0,1,5, 1,7,  0,0,0,0,7,1,1};
    tbl[11] = '{0,0,0,0, 1,0,1,5, 1,7,  0,1,0,0,5,1,0};
    tbl[12] = '{0,0,0,0, 1,1,1,6, 0,2,  0,1,0,1,6,1,2};
    tbl[13] = '{0,0,0,0, 0,0,0,0, 0,2,  0,0,0,0,2,0,0};
    tbl[14] = '{0,0,0,0, 0,0,0,0, 0,2,  0,0,0,0,2,1,0};

    drive(0,0,0,0, 0,0,0,0, 0,0);
    bus.mem_rdata_p1 = 64'd0;
    bus.mem_rdata_p2 = 64'd0;
    step(); step();
    init_mem = 1'b0;
    step();
    chk("reset_col_gnt",  64'(bus.col_gnt), 0);
    chk("reset_val_gnt",  64'(bus.val_gnt), 0);
    chk("reset_rd_valid", 64'(bus.rd_valid), 0);
    chk("reset_rd_data",  bus.rd_data, 0);
    chk("reset_wdata",    bus.mem_wdata, 0);
    resetGeral = 1'b1;

    pend_data = 64'd0;
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].cr, tbl[i].cw, tbl[i].cj, tbl[i].ca, tbl[i].vr, tbl[i].vw, tbl[i].vj,
            tbl[i].va, tbl[i].gj, tbl[i].ga);
      #1;
      chk($sformatf("v%0d_col_gnt", i), 64'(bus.col_gnt), 64'(tbl[i].e_cg));
      chk($sformatf("v%0d_val_gnt", i), 64'(bus.val_gnt), 64'(tbl[i].e_vg));
      chk($sformatf("v%0d_wrenP1", i), 64'(bus.wrenP1), 64'(tbl[i].e_w1));
      chk($sformatf("v%0d_wrenP2", i), 64'(bus.wrenP2), 64'(tbl[i].e_w2));
      chk($sformatf("v%0d_mem_addr", i), 64'(bus.mem_addr), 64'(tbl[i].e_addr));
      chk($sformatf("v%0d_mem_wdata", i), bus.mem_wdata,
          (tbl[i].e_w1 || tbl[i].e_w2) ? (tbl[i].e_cg ? 64'hFF : 64'hAA) : 64'd0);
      chk($sformatf("v%0d_rd_valid", i), 64'(bus.rd_valid), 64'(tbl[i].e_rv));
      if (tbl[i].e_rv) begin
        chk($sformatf("v%0d_rd_src", i), 64'(bus.rd_src), 64'(tbl[i].e_rs));
        chk($sformatf("v%0d_rd_data", i), bus.rd_data, pend_data);
      end
      jg = tbl[i].e_cg ? tbl[i].cj : (tbl[i].e_vg ? tbl[i].vj : tbl[i].gj);
      pend_data = jg ? mem2[tbl[i].e_addr] : mem1[tbl[i].e_addr];
      step();
    end

    // Both requesters held: 32 COL grants, one VGA slot, 32 VAL grants, slot, back to COL.
    drive(1,0,0,1, 1,0,1,2, 0,11);
    step();
    n = 0;
    while (bus.col_gnt && n < 100) begin n++; step(); end
    chk("col_burst_len", 64'(n), 32);
    chk("gap1_val_gnt", 64'(bus.val_gnt), 0);
    chk("gap1_mem_addr", 64'(bus.mem_addr), 11);
    step();
    chk("gap1_rd_valid", 64'(bus.rd_valid), 1);
    chk("gap1_rd_src", 64'(bus.rd_src), 0);
    n = 0;
    while (bus.val_gnt && n < 100) begin n++; step(); end
    chk("val_burst_len", 64'(n), 32);
    chk("gap2_col_gnt", 64'(bus.col_gnt), 0);
    step();
    chk("after_gap2_col_gnt", 64'(bus.col_gnt), 1);

    // Reset in the middle of a write burst, then the counter restarts.
    drive(0,0,0,0, 0,0,0,0, 0,0);
    step();
    drive(1,1,0,4, 0,0,0,0, 0,0);
    step();
    n = 0;
    while (bus.col_gnt && n < 10) begin n++; step(); end
    chk("pre_reset_grants", 64'(n), 10);
    resetGeral = 1'b0;
    #1;
    chk("mid_reset_col_gnt", 64'(bus.col_gnt), 0);
    chk("mid_reset_wrenP1", 64'(bus.wrenP1), 0);
    chk("mid_reset_rd_valid", 64'(bus.rd_valid), 0);
    chk("mid_reset_wdata", bus.mem_wdata, 0);
    step();
    resetGeral = 1'b1;
    #1;
    chk("post_reset_col_gnt", 64'(bus.col_gnt), 0);
    step();
    n = 0;
    while (bus.col_gnt && n < 100) begin n++; step(); end
    chk("post_reset_burst_len", 64'(n), 32);

    // Random run against the reference model.
    drive(0,0,0,0, 0,0,0,0, 0,0);
    resetGeral = 1'b0;
    step();
    resetGeral = 1'b1;
    m_holder = 0; m_run = 0; m_prev = 0; m_gap = 0; p_valid = 0; p_src = 0; p_data = 0;
    for (int c = 0; c < 3000; c++) begin
      int own, other;
      logic we, jog, req_o, req_p;
      logic [4:0] addr;
      logic [63:0] wd;
      bus.col_req = ($urandom_range(0, 9) < 8);
      bus.val_req = ($urandom_range(0, 9) < 7);
      bus.col_we = 1'($urandom); bus.col_jogador = 1'($urandom); bus.col_addr = 5'($urandom);
      bus.val_we = 1'($urandom); bus.val_jogador = 1'($urandom); bus.val_addr = 5'($urandom);
      bus.col_wdata = {$urandom, $urandom};
      bus.val_wdata = {$urandom, $urandom};
      bus.vga_jogador = 1'($urandom); bus.vga_addr = 5'($urandom);
      #1;
      if (m_gap) own = 0;
      else if (m_holder == 1 && bus.col_req) own = 1;
      else if (m_holder == 2 && bus.val_req) own = 2;
      else own = 0;
      we   = (own == 1) ? bus.col_we : (own == 2) ? bus.val_we : 1'b0;
      jog  = (own == 1) ? bus.col_jogador : (own == 2) ? bus.val_jogador : bus.vga_jogador;
      addr = (own == 1) ? bus.col_addr : (own == 2) ? bus.val_addr : bus.vga_addr;
      wd   = !we ? 64'd0 : (own == 1) ? bus.col_wdata : bus.val_wdata;
      chk("rnd_col_gnt", 64'(bus.col_gnt), 64'(own == 1));
      chk("rnd_val_gnt", 64'(bus.val_gnt), 64'(own == 2));
      chk("rnd_wrenP1", 64'(bus.wrenP1), 64'(we && !jog));
      chk("rnd_wrenP2", 64'(bus.wrenP2), 64'(we && jog));
      chk("rnd_mem_addr", 64'(bus.mem_addr), 64'(addr));
      chk("rnd_mem_wdata", bus.mem_wdata, wd);
      chk("rnd_rd_valid", 64'(bus.rd_valid), 64'(p_valid));
      if (p_valid) begin
        chk("rnd_rd_src", 64'(bus.rd_src), 64'(p_src));
        chk("rnd_rd_data", bus.rd_data, p_data);
      end
      p_valid = !we;
      p_src   = 2'(own);
      p_data  = jog ? mem2[addr] : mem1[addr];
      if (m_gap) begin
        other = (m_prev == 1) ? 2 : 1;
        req_o = (other == 1) ? bus.col_req : bus.val_req;
        req_p = (m_prev == 1) ? bus.col_req : bus.val_req;
        m_holder = req_o ? other : (req_p ? m_prev : 0);
        m_run = 0;
        m_gap = 0;
      end else if (own != 0) begin
        m_run++;
        if (m_run == MAXB) begin
          m_gap = 1; m_prev = own; m_holder = 0; m_run = 0;
        end
      end else begin
        if (m_holder == 0) begin
          m_holder = bus.col_req ? 1 : (bus.val_req ? 2 : 0);
        end else begin
          other = (m_holder == 1) ? 2 : 1;
          req_o = (other == 1) ? bus.col_req : bus.val_req;
          m_holder = req_o ? other : 0;
        end
        m_run = 0;
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/arbitro_memoria_tabuleiro.md
ARBITRO_MEMORIA_TABULEIRO -- requirements
Module: arbitro_memoria_tabuleiro

Interface
REQ-001 SHALL have parameter MAX_BURST, default 32, max consecutive granted cycles per requester before a forced VGA slot.
REQ-002 SHALL have parameter ADDR_W, default 5, board word address width (32 rows).
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 resetGeral  input  1  reset, asynchronous, active-low.
REQ-005 col_req  input  1  colisor requests memory access.
REQ-006 col_jogador  input  1  colisor target board, 0 = P1, 1 = P2.
REQ-007 col_we  input  1  colisor write enable.
REQ-008 col_addr  input  ADDR_W  colisor word address.
REQ-009 col_wdata  input  64  colisor write data.
REQ-010 col_gnt  output  1  colisor owns memory this cycle.
REQ-011 val_req  input  1  validador requests memory access.
REQ-012 val_jogador  input  1  validador target board.
REQ-013 val_we  input  1  validador write enable.
REQ-014 val_addr  input  ADDR_W  validador word address.
REQ-015 val_wdata  input  64  validador write data.
REQ-016 val_gnt  output  1  validador owns memory this cycle.
REQ-017 vga_jogador  input  1  board shown by VGA.
REQ-018 vga_addr  input  ADDR_W  VGA read address.
REQ-019 mem_rdata_p1  input  64  P1 memory read data, one-cycle synchronous-read latency.
REQ-020 mem_rdata_p2  input  64  P2 memory read data, same latency.
REQ-021 mem_addr  output  ADDR_W  shared address to both memories.
REQ-022 mem_wdata  output  64  shared write data, 0 when no write.
REQ-023 wrenP1 / wrenP2  output  1 each  write enables, P1 / P2 memory.
REQ-024 rd_data, rd_valid, rd_src  output  64/1/2  returned read word, valid strobe, owner (0 VGA, 1 COL, 2 VAL).

Function
REQ-025 FSM states: VGA, COL, VAL, GAP; registered; outputs decoded from state and current inputs.
REQ-026 From VGA: col_req -> COL; else val_req -> VAL; else VGA (fixed priority COL > VAL).
REQ-027 col_gnt = (state==COL) && col_req; val_gnt = (state==VAL) && val_req; never both high.
REQ-028 In COL/VAL: stay while req high and burst count < MAX_BURST; req low -> re-arbitrate as from VGA, excluding the requester just served, at the same edge.
REQ-029 Burst counter: 6 bits, cleared on entry to COL/VAL, +1 per granted cycle; at MAX_BURST granted cycles with req still high -> GAP.
REQ-030 GAP lasts exactly 1 cycle with VGA access; then the other requester wins if requesting, else the same requester, else VGA.
REQ-031 Granted cycle: mem_addr = owner addr; wrenP1 = gnt && we && !jogador; wrenP2 = gnt && we && jogador; mem_wdata = owner wdata when writing.
REQ-032 VGA/GAP, or state COL/VAL with req low: mem_addr = vga_addr, no write, access counted as VGA read.
REQ-033 Every non-write access cycle N yields rd_valid=1 in cycle N+1, rd_src = owner of N, rd_data = mem_rdata_p1/p2 per jogador registered at N.
REQ-034 Write cycles produce no rd_valid; at most one access per cycle, so rd_valid strobes are in issue order.

Reset
REQ-035 resetGeral low asynchronously forces state VGA, burst counter 0, read pipeline cleared; col_gnt, val_gnt, wrenP1, wrenP2, rd_valid, rd_src, rd_data, mem_wdata = 0 immediately, including mid-burst; first VGA read issued on first edge after release.

Verification
REQ-036 Idle, vga_jogador=1, vga_addr=7 -> mem_addr=7, rd_valid each cycle, rd_src=0, rd_data = mem_rdata_p2 of previous cycle.
REQ-037 col_req=1, col_we=1, col_jogador=0, col_addr=3, col_wdata=64'hFF for 1 cycle -> next cycle col_gnt=1, wrenP1=1, mem_addr=3, wrenP2=0, no rd_valid.
REQ-038 col_req and val_req rise same edge, both held -> COL granted 32 cycles, GAP 1 cycle (rd_src=0 next), then VAL granted.
REQ-039 val read of addr 5 board P2 -> rd_valid one cycle after val_gnt, rd_src=2, rd_data = memory word 5 of P2.
REQ-040 resetGeral pulled low during COL burst at count 10 -> col_gnt, wrenP1 drop same cycle; after release state VGA, count restarts at 0 on next grant.
